// File: rtl/us_cmd_tx_engine.sv
// us_cmd_tx_engine: pops us_cmd_fifo entries and sends CPLD / MWr32 TLPs on the 32-bit TRN TX port.
// Optional macro US_TX_BOUNDARY_CHK_EN drops (and drains) MWr32 entries that cross a 4 KB boundary.
module us_cmd_tx_engine #(
  parameter logic [1:0] CPL_TYPE  = 2'b00,
  parameter logic [1:0] WR32_TYPE = 2'b01
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [15:0]  completer_id_i,
  input  logic         cfg_bus_mstr_enable_i,
  input  logic         us_cmd_fifo_empty_i,
  output logic         us_cmd_fifo_rd_en_o,
  input  logic [127:0] us_cmd_fifo_dout_i,
  input  logic [31:0]  pl_data_i,
  input  logic         pl_valid_i,
  output logic         pl_rd_o,
  output logic [31:0]  trn_td_o,
  output logic         trn_tsof_n_o,
  output logic         trn_teof_n_o,
  output logic         trn_tsrc_rdy_n_o,
  input  logic         trn_tdst_rdy_n_i,
  input  logic [5:0]   trn_tbuf_av_i,
  output logic         up_wr_cmd_compl_o,
  output logic [1:0]   cmd_id_o,
  output logic         err_o
);
  typedef enum logic [3:0] {IDLE, POP, LOAD, WAIT, H0, H1, H2, DATA, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [95:0] cmd_q;
  logic [7:0]  cnt_q, cnt_d, n_dw;
  logic        err_q, err_d;
  logic        is_wr, last, pl_ok, unused_hi;
  logic [1:0]  ld_type;
  logic [31:0] hdr0, hdr1, hdr2;
  assign unused_hi = ^us_cmd_fifo_dout_i[127:96];
  assign ld_type   = us_cmd_fifo_dout_i[63:62];
  assign is_wr     = cmd_q[63:62] == WR32_TYPE;
  assign n_dw      = {{1'b0, cmd_q[61:57]} + 6'd1, 2'b00};
  assign last      = cnt_q == n_dw - 8'd1;
  assign pl_ok     = !is_wr || pl_valid_i;
  assign err_o     = err_q;
`ifdef US_TX_BOUNDARY_CHK_EN
  logic [7:0] ld_n;
  logic       oob;
  assign ld_n = {{1'b0, us_cmd_fifo_dout_i[61:57]} + 6'd1, 2'b00};
  assign oob  = ({2'b0, us_cmd_fifo_dout_i[11:0]} + {4'b0, ld_n, 2'b00}) > 14'd4096;
`endif
  assign hdr0 = is_wr ? {8'h40, 16'h0, n_dw}
                      : {8'h4A, 1'b0, cmd_q[54:52], 4'b0, cmd_q[51], cmd_q[50], cmd_q[49:48], 2'b0, cmd_q[47:38]};
  assign hdr1 = is_wr ? {completer_id_i, 6'b0, cmd_q[56:55], 8'hFF} : {completer_id_i, 4'b0, 12'd4};
  assign hdr2 = is_wr ? {cmd_q[31:2], 2'b00} : {cmd_q[37:22], cmd_q[21:14], 1'b0, cmd_q[5:0], 1'b0};
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      cmd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      if (state_q == LOAD) cmd_q <= us_cmd_fifo_dout_i[95:0];
    end
  end
  always_comb begin
    state_d             = state_q;
    cnt_d               = cnt_q;
    err_d               = err_q;
    us_cmd_fifo_rd_en_o = 1'b0;
    pl_rd_o             = 1'b0;
    trn_td_o            = '0;
    trn_tsof_n_o        = 1'b1;
    trn_teof_n_o        = 1'b1;
    trn_tsrc_rdy_n_o    = 1'b1;
    up_wr_cmd_compl_o   = 1'b0;
    cmd_id_o            = '0;
    case (state_q)
      IDLE: state_d = (!us_cmd_fifo_empty_i && trn_tbuf_av_i != '0) ? POP : IDLE;
      POP: begin
        us_cmd_fifo_rd_en_o = 1'b1;
        state_d             = LOAD;
      end
      LOAD: begin
        cnt_d = '0;
        if (ld_type != CPL_TYPE && ld_type != WR32_TYPE) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
`ifdef US_TX_BOUNDARY_CHK_EN
        else if (ld_type == WR32_TYPE && oob) begin
          err_d   = 1'b1;
          state_d = DRAIN;
        end
`endif
        else state_d = (ld_type == WR32_TYPE && !cfg_bus_mstr_enable_i) ? WAIT : H0;
      end
      WAIT: state_d = cfg_bus_mstr_enable_i ? H0 : WAIT;
      H0: begin
        trn_td_o         = hdr0;
        trn_tsof_n_o     = 1'b0;
        trn_tsrc_rdy_n_o = 1'b0;
        state_d          = trn_tdst_rdy_n_i ? H0 : H1;
      end
      H1: begin
        trn_td_o         = hdr1;
        trn_tsrc_rdy_n_o = 1'b0;
        state_d          = trn_tdst_rdy_n_i ? H1 : H2;
      end
      H2: begin
        trn_td_o         = hdr2;
        trn_tsrc_rdy_n_o = 1'b0;
        state_d          = trn_tdst_rdy_n_i ? H2 : DATA;
      end
      DATA: begin
        trn_td_o         = is_wr ? pl_data_i : cmd_q[95:64];
        trn_tsrc_rdy_n_o = !pl_ok;
        trn_teof_n_o     = is_wr && !last;
        if (pl_ok && !trn_tdst_rdy_n_i) begin
          pl_rd_o = is_wr;
          cnt_d   = cnt_q + 8'd1;
          state_d = (!is_wr || last) ? DONE : DATA;
        end
      end
      // dropped MWr32: consume its payload so the stream stays aligned with the FIFO
      DRAIN: begin
        pl_rd_o = pl_valid_i;
        if (pl_valid_i) begin
          cnt_d   = cnt_q + 8'd1;
          state_d = last ? DONE : DRAIN;
        end
      end
      DONE: begin
        up_wr_cmd_compl_o = is_wr;
        cmd_id_o          = is_wr ? cmd_q[56:55] : 2'b00;
        state_d           = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_us_cmd_tx_engine.sv
// tb_us_cmd_tx_engine: scoreboard bench for us_cmd_tx_engine with a FIFO/payload source model.
module tb_us_cmd_tx_engine;
  localparam logic [15:0] CID = 16'hABCD;
  typedef struct packed {logic [31:0] d; logic sof; logic eof;} beat_t;
  typedef struct packed {logic [1:0] id; logic sent;} cpl_t;
  logic clk = 0, rst = 1;
  logic mstr = 1, empty = 1, rd_en, pl_valid = 0, pl_rd, tsof_n, teof_n, tsrc_n, dst_n = 0, compl, err;
  logic [127:0] dout = '0;
  logic [31:0] pl_data = '0, td;
  logic [5:0] tbuf = 6'd8;
  logic [1:0] cmd_id;
  logic [127:0] fifo_q[$];
  logic [31:0] pl_q[$], got[$];
  beat_t exp_q[$];
  cpl_t cexp_q[$];
  int n_chk = 0, n_fail = 0, sof_cnt = 0, beat_cnt = 0, mode = 0;
  logic exp_err = 0;
  always #5 clk = ~clk;
  us_cmd_tx_engine dut (
    .clk(clk), .rst(rst), .completer_id_i(CID), .cfg_bus_mstr_enable_i(mstr),
    .us_cmd_fifo_empty_i(empty), .us_cmd_fifo_rd_en_o(rd_en), .us_cmd_fifo_dout_i(dout),
    .pl_data_i(pl_data), .pl_valid_i(pl_valid), .pl_rd_o(pl_rd),
    .trn_td_o(td), .trn_tsof_n_o(tsof_n), .trn_teof_n_o(teof_n), .trn_tsrc_rdy_n_o(tsrc_n),
    .trn_tdst_rdy_n_i(dst_n), .trn_tbuf_av_i(tbuf),
    .up_wr_cmd_compl_o(compl), .cmd_id_o(cmd_id), .err_o(err));
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  // source side: FIFO with one-cycle read latency and a payload stream
  initial begin
    logic s_rd, s_pl;
    int cyc = 0;
    forever begin
      @(negedge clk);
      s_rd = rd_en;
      s_pl = pl_rd;
      @(posedge clk);
      #1;
      cyc++;
      if (s_rd && fifo_q.size() > 0) dout = fifo_q.pop_front();
      if (s_pl && pl_q.size() > 0) void'(pl_q.pop_front());
      empty = fifo_q.size() == 0;
      if (mode == 0) begin
        dst_n = 0;
        pl_valid = pl_q.size() > 0;
      end else if (mode == 1) begin
        dst_n = ((cyc / 3) % 2) == 1;
        pl_valid = pl_q.size() > 0 && (cyc % 5) != 4;
      end else begin
        dst_n = $urandom_range(0, 3) == 0;
        pl_valid = pl_q.size() > 0 && $urandom_range(0, 3) != 0;
      end
      pl_data = pl_valid ? pl_q[0] : 32'h0;
    end
  end
  // monitor: pops expectations whenever the DUT transfers a beat or pulses completion
  initial begin
    beat_t e;
    cpl_t c;
    int mc = 0, last_eof = -10;
    forever begin
      @(negedge clk);
      mc++;
      if (!rst) begin
        if (!tsrc_n && !dst_n) begin
          beat_cnt++;
          if (!tsof_n) begin
            sof_cnt++;
            got.delete();
          end
          got.push_back(td);
          if (!teof_n) last_eof = mc;
          if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_beat: got %h expected none", td);
          end else begin
            e = exp_q.pop_front();
            chk("beat_data", td, e.d);
            chk("beat_sof_eof", {30'b0, !tsof_n, !teof_n}, {30'b0, e.sof, e.eof});
          end
        end
        if (compl) begin
          if (cexp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_compl: got cmd_id %0d expected none", cmd_id);
          end else begin
            c = cexp_q.pop_front();
            chk("compl_cmd_id", {30'b0, cmd_id}, {30'b0, c.id});
            if (c.sent) chk("compl_after_eof", mc - last_eof, 1);
          end
        end
      end
    end
  end
  task automatic issue_cpl(input logic [2:0] tc, input logic tdb, input logic ep, input logic [1:0] attr,
                           input logic [9:0] len, input logic [15:0] rid, input logic [7:0] tag,
                           input logic [7:0] be, input logic [5:0] a6, input logic [31:0] data);
    fifo_q.push_back({32'h0, data, 2'b00, 7'b0, tc, tdb, ep, attr, len, rid, tag, be, a6});
    exp_q.push_back({{1'b0, 2'b10, 5'b01010, 1'b0, tc, 4'b0, tdb, ep, attr, 2'b0, len}, 1'b1, 1'b0});
    exp_q.push_back({{CID, 16'h0004}, 1'b0, 1'b0});
    exp_q.push_back({{rid, tag, 1'b0, a6, 1'b0}, 1'b0, 1'b0});
    exp_q.push_back({data, 1'b0, 1'b1});
  endtask
  task automatic issue_wr(input logic [4:0] len, input logic [1:0] id, input logic [31:0] addr,
                          input int base, input bit rnd);
    int n = (len + 1) * 4;
    bit drop = 0;
    logic [31:0] w;
`ifdef US_TX_BOUNDARY_CHK_EN
    drop = (int'(addr[11:0]) + n * 4) > 4096;
`endif
    fifo_q.push_back({64'h0, 2'b01, len, id, 23'b0, addr});
    if (!drop) begin
      exp_q.push_back({{8'h40, 14'h0, 10'(n)}, 1'b1, 1'b0});
      exp_q.push_back({{CID, 6'b0, id, 8'hFF}, 1'b0, 1'b0});
      exp_q.push_back({{addr[31:2], 2'b00}, 1'b0, 1'b0});
    end else exp_err = 1;
    for (int i = 0; i < n; i++) begin
      w = rnd ? $urandom : 32'(base + i);
      pl_q.push_back(w);
      if (!drop) exp_q.push_back({w, 1'b0, i == n - 1});
    end
    cexp_q.push_back({id, !drop});
  endtask
  task automatic wait_idle(input int budget);
    int k = 0;
    while ((fifo_q.size() || exp_q.size() || cexp_q.size() || pl_q.size()) && k < budget) begin
      tick();
      k++;
    end
    n_chk++;
    if (k >= budget) begin
      n_fail++;
      $display("FAIL idle_timeout: got %0d beats pending expected 0", exp_q.size());
    end
    repeat (4) @(posedge clk);
    #2;
  endtask
  task automatic reset_vals();
    chk("rst_rd_en", rd_en, 0);
    chk("rst_pl_rd", pl_rd, 0);
    chk("rst_td", td, 0);
    chk("rst_sof_eof_src", {29'b0, tsof_n, teof_n, tsrc_n}, 32'h7);
    chk("rst_compl", compl, 0);
    chk("rst_cmd_id", cmd_id, 0);
    chk("rst_err", err, 0);
  endtask
  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    int s, b0, k;
    logic [31:0] t;
    repeat (3) tick();
    reset_vals();
    rst = 0;
    tick();
    // 1: CPL, held off while tbuf_av is zero
    tbuf = 0;
    issue_cpl(0, 0, 0, 0, 10'd1, 16'h1234, 8'h05, 8'h0F, 6'd4, 32'hDEADBEEF);
    repeat (10) tick();
    chk("tbuf_block_sof", sof_cnt, 0);
    tbuf = 8;
    wait_idle(200);
    chk("t1_beats", got.size(), 4);
    chk("t1_dw0", got[0], 32'h4A000001);
    t = got[2];
    chk("t1_tag", {24'b0, t[15:8]}, 32'h05);
    chk("t1_data", got[3], 32'hDEADBEEF);
    // 2 and 3: 32-DW MWr32, with and without back-pressure
    for (int m = 0; m < 2; m++) begin
      mode = m;
      issue_wr(5'd7, 2'd1, 32'h00001000, 0, 0);
      wait_idle(400);
      chk("t2_beats", got.size(), 35);
      chk("t2_dw0", got[0], 32'h40000020);
      chk("t2_dw2", got[2], 32'h00001000);
      chk("t2_last", got[34], 31);
    end
    mode = 0;
    // 4: bus mastering off holds the WR32 and the CPL behind it
    mstr = 0;
    s = sof_cnt;
    issue_wr(5'd3, 2'd2, 32'h20000100, 100, 0);
    issue_cpl(3'd2, 1, 0, 2'd1, 10'd1, 16'h5678, 8'h22, 8'hFF, 6'd8, 32'h0BADF00D);
    repeat (20) tick();
    chk("t4_no_sof", sof_cnt, s);
    mstr = 1;
    wait_idle(400);
    chk("t4_sof_after", sof_cnt, s + 2);
    // 5: reset in the middle of the payload
    b0 = beat_cnt;
    issue_wr(5'd7, 2'd3, 32'h00003000, 200, 0);
    k = 0;
    while (beat_cnt < b0 + 13 && k < 500) begin
      tick();
      k++;
    end
    chk("t5_reach_beat10", beat_cnt >= b0 + 13, 1);
    rst = 1;
    exp_q.delete();
    cexp_q.delete();
    pl_q.delete();
    fifo_q.delete();
    exp_err = 0;
    tick();
    reset_vals();
    rst = 0;
    issue_cpl(0, 0, 0, 0, 10'd1, 16'h0001, 8'h07, 8'h0F, 6'd0, 32'hCAFEF00D);
    wait_idle(200);
    chk("t5_restart_beats", got.size(), 4);
    // 6: WR32 crossing a 4 KB boundary
    s = sof_cnt;
    issue_wr(5'd7, 2'd0, 32'h00000FC0, 300, 0);
    wait_idle(400);
`ifdef US_TX_BOUNDARY_CHK_EN
    chk("t6_sof", sof_cnt, s);
`else
    chk("t6_sof", sof_cnt, s + 1);
`endif
    chk("t6_err", err, exp_err);
    // 7: random mix with random back-pressure
    mode = 2;
    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 9);
      mstr = $urandom_range(0, 3) != 0;
      tbuf = 6'($urandom_range(0, 4));
      if (k < 4)
        issue_cpl(3'($urandom), 1'($urandom), 1'($urandom), 2'($urandom), 10'($urandom), 16'($urandom),
                  8'($urandom), 8'($urandom), 6'($urandom), $urandom);
      else if (k < 9) issue_wr(5'($urandom_range(0, 7)), 2'($urandom), $urandom, 0, 1);
      else begin
        fifo_q.push_back({64'h0, 1'b1, 1'($urandom), 30'h0, 32'($urandom)});
        exp_err = 1;
      end
      repeat ($urandom_range(0, 6)) tick();
    end
    mstr = 1;
    tbuf = 8;
    wait_idle(20000);
    chk("t7_err", err, exp_err);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
